mont_final_reduce: RTL
======================

// Module: mont_final_reduce
// PURPOSE
//  Output stage directly downstream of the 6-bit Montgomery multiplier array.
//  - Captures the 9-bit partial result S when the array's done rises.
//  - Reduces S into [0, M) by iterative conditional subtraction, one per cycle.
//  - Presents the 6-bit residue on a valid/ready interface.
//  - Flags invalid moduli, iteration overflow and dropped results.
// PARAMETERS
//  N        6  operand/modulus width (X, Y, M)
//  SW       9  input partial-result width, always N+3
//  MAX_ITER 8  max subtractions before err; counter is clog2(MAX_ITER+1) bits
// PORTS
//  clk      in   1   single clock, rising edge
//  rst      in   1   asynchronous, active-low reset
//  s_in     in   SW  partial result from multiplier; valid while done_in=1
//  m_in     in   N   modulus; sampled together with s_in
//  done_in  in   1   multiplier done (level); rising edge = new result
//  r_out    out  N   reduced residue; stable while r_valid=1
//  r_valid  out  1   residue available
//  r_ready  in   1   consumer accepts when r_valid & r_ready
//  err      out  1   valid with r_valid: M even/zero, or MAX_ITER exceeded
//  busy     out  1   high in REDUCE or HOLD
//  overrun  out  1   1-cycle pulse: a done_in rise was dropped while busy
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; acc, mod, iter, done_d, r_out, err = 0;
//    r_valid, busy, overrun = 0. Reset mid-REDUCE/HOLD aborts with no output.
//  - Edge detect: done_d <= done_in each cycle; rise = done_in & ~done_d.
//    A level held high captures once only.
//  - IDLE: on rise, acc<=s_in, mod<=m_in, iter<=0 -> REDUCE.
//    If m_in==0 or m_in[0]==0: go straight to HOLD with r_out=0, err=1.
//  - REDUCE, one edge per step:
//    - acc>=mod and iter<MAX_ITER: acc<=acc-mod (SW-bit, no borrow possible), iter++.
//    - acc<mod: r_out<=acc[N-1:0], err<=0, r_valid<=1 -> HOLD.
//    - acc>=mod and iter==MAX_ITER: r_out<=0, err<=1, r_valid<=1 -> HOLD.
//  - Latency: with k subtractions (k<=MAX_ITER), r_valid rises on the
//    (k+1)th edge after the capture edge.
//  - HOLD: r_out, err, r_valid held until r_valid&r_ready. On that edge:
//    r_valid<=0 -> IDLE. A rise on the same edge is dropped.
//  - Any rise seen outside IDLE: overrun=1 for one cycle; state, acc and
//    r_out are unchanged.
//  - r_ready is ignored outside HOLD. There is no combinational path from
//    r_ready to r_valid. All outputs are registered.
//  - Comparison is unsigned over SW bits: mod is zero-extended, acc<mod
//    implies acc<2^N.
// STRUCTURE
//  Shared package mont_pkg:
//   - constants N=6, SW=9
//   - state encoding IDLE=2'd0, REDUCE=2'd1, HOLD=2'd2
//   - unused 2'd3 decodes to IDLE
//  Sub-module mont_cond_sub (combinational, SW bits):
//   - inputs a, m
//   - outputs ge = (a>=m) and diff = a-m
//   - reused later by the pre-multiply operand range checker
//  Top: FSM, edge detector, iteration counter, output registers.
// TESTING
//  1. M=13, S=30, done rises -> 2 subtractions; r_valid on edge 3 after
//     capture; r_out=4, err=0.
//  2. M=13, S=5 -> r_valid on edge 1, r_out=5. M=13, S=13 -> r_out=0 after
//     1 subtraction.
//  3. M=12, S=30 -> HOLD immediately; r_out=0, err=1. M=0 -> same.
//  4. M=13, S=200 (needs 15 subtractions) -> after 8 subtractions r_out=0,
//     err=1, r_valid on edge 9.
//  5. r_ready=0 for 5 cycles in HOLD -> r_out/r_valid stable; r_ready=1 ->
//     r_valid drops next edge. Second done rise during HOLD -> one overrun
//     pulse, r_out unchanged. done_in held high 20 cycles -> one capture only.
//  6. Assert rst=0 mid-REDUCE (case 4) -> outputs clear immediately without
//     a clock edge. After release, case 1 replays with correct timing.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the Montgomery output stage.
package mont_pkg;

  // Operand/modulus width and the wider partial-result width.
  localparam int N        = 6;
  localparam int SW       = N + 3;

  // Subtraction budget and the counter width needed to reach it.
  localparam int MAX_ITER = 8;
  localparam int IW       = $clog2(MAX_ITER + 1);

  // The unused code 2'd3 falls into the IDLE branch of the FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // A usable Montgomery modulus must be odd, which also rules out zero.
  function automatic logic modValid(input logic [N-1:0] m);
    return (m != '0) && m[0];
  endfunction

endpackage

// File: rtl/mont_cond_sub.sv
// Combinational compare-and-subtract step, shared with the operand range checker.
module mont_cond_sub #(
  parameter int W = mont_pkg::SW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  output logic         ge,
  output logic [W-1:0] diff
);

  // Unsigned compare and difference; diff is only meaningful when ge is set.
  always_comb begin
    ge   = (a >= m);
    diff = a - m;
  end

endmodule

// File: rtl/mont_final_reduce.sv
// Final reduction stage: captures the multiplier result, subtracts the modulus
// until the residue is in range, and hands it over on a valid/ready interface.
module mont_final_reduce
  import mont_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] s_in,
  input  logic [N-1:0]  m_in,
  input  logic          done_in,
  output logic [N-1:0]  r_out,
  output logic          r_valid,
  input  logic          r_ready,
  output logic          err,
  output logic          busy,
  output logic          overrun
);

  state_e        state_q;
  logic [SW-1:0] acc_q;
  logic [N-1:0]  mod_q;
  logic [IW-1:0] iter_q;
  logic          doneDly_q;
  logic [N-1:0]  rOut_q;
  logic          rValid_q;
  logic          err_q;
  logic          busy_q;
  logic          overrun_q;

  logic          rise;
  logic          accGe;
  logic [SW-1:0] accDiff;
  logic [SW-1:0] modWide;

  // A new result is announced by the rising edge of the done level.
  always_comb begin
    rise    = done_in & ~doneDly_q;
    modWide = {{(SW - N){1'b0}}, mod_q};
  end

  mont_cond_sub #(.W(SW)) uSub (
    .a    (acc_q),
    .m    (modWide),
    .ge   (accGe),
    .diff (accDiff)
  );

  // Single FSM: capture, iterative subtraction, and hold until handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mod_q     <= '0;
      iter_q    <= '0;
      doneDly_q <= 1'b0;
      rOut_q    <= '0;
      rValid_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      doneDly_q <= done_in;
      overrun_q <= 1'b0;
      case (state_q)
        REDUCE: begin
          overrun_q <= rise;
          if (!accGe) begin
            rOut_q   <= acc_q[N-1:0];
            err_q    <= 1'b0;
            rValid_q <= 1'b1;
            state_q  <= HOLD;
          end else if (iter_q < IW'(MAX_ITER)) begin
            acc_q  <= accDiff;
            iter_q <= iter_q + 1'b1;
          end else begin
            rOut_q   <= '0;
            err_q    <= 1'b1;
            rValid_q <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          overrun_q <= rise;
          if (r_ready) begin
            rValid_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          if (rise) begin
            acc_q  <= s_in;
            mod_q  <= m_in;
            iter_q <= '0;
            busy_q <= 1'b1;
            if (!modValid(m_in)) begin
              rOut_q   <= '0;
              err_q    <= 1'b1;
              rValid_q <= 1'b1;
              state_q  <= HOLD;
            end else begin
              state_q  <= REDUCE;
            end
          end
        end
      endcase
    end
  end

  assign r_out   = rOut_q;
  assign r_valid = rValid_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
